inst_fetch_unit: RTL and testbench

//  Fetch stage of the multi-cycle core; sits directly upstream of the instruction ROM.
//  - Owns the PC and drives the ROM byte address.
//  - Waits a configurable read latency, then latches the returned word into the IR.
//  - Presents IR plus its PC to decode through a valid/ready handshake.
//  - Accepts jump/branch redirects (jal/jalr/branch targets) from execute.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_wait_ctr.sv | 37 +++
 rtl/inst_fetch_unit.sv | 133 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage: the fetch FSM state
//   type, instruction size and the canonical NOP encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // waiting on the ROM, capture when the wait expires
        VALID = 2'd1,   // IR presented to decode
        HALT  = 2'd2    // misaligned redirect seen; frozen until reset
    } fetch_state_t;

    localparam int          INST_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    // Instructions are word sized, so a legal target has its two low bits clear.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// -----------------------------------------------------------------------------
// fetch_wait_ctr
//   2-bit ROM latency counter. Counts while enabled, returns to zero on clear.
//   Clear has priority over enable.
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   i_clr    in   force count to zero on the next edge
//   i_en     in   increment on the next edge
//   o_count  out  current count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fetch_wait_ctr (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [1:0] o_count
);

    logic [1:0] r_count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
        end else if (i_clr) begin
            r_count <= 2'd0;
        end else if (i_en) begin
            r_count <= r_count + 2'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Fetch stage of the multi-cycle core. Owns the PC, drives the ROM byte
//   address, waits ROM_LATENCY extra cycles, captures the returned word into
//   the IR and offers IR + PC to decode over a valid/ready handshake. Redirects
//   from execute replace the PC; a misaligned redirect halts fetch until reset.
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   rom_addr         out  byte address to ROM (always the PC)
//   rom_inst         in   instruction word returned by ROM
//   ir_out           out  latched instruction register
//   ir_pc            out  PC of the instruction in ir_out
//   ir_valid         out  ir_out/ir_pc valid for decode
//   ir_ready         in   decode consumes the IR when ir_valid=1
//   redirect_valid   in   load redirect_target into the PC
//   redirect_target  in   new PC (byte address)
//   misalign_fault   out  sticky: a redirect target was not word aligned
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 17,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                ROM_LATENCY = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              misalign_fault
);

    localparam logic [1:0] LAT = 2'(ROM_LATENCY);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic              r_fault;

    logic [1:0]        w_wait_cnt;
    logic              w_wait_done;
    logic              w_aligned;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_wait_done = (w_wait_cnt == LAT);
    assign w_aligned   = is_word_aligned(redirect_target[1:0]);
    // Natural ADDR_W-bit wrap: the top word rolls over to address 0.
    assign w_pc_next   = r_pc + ADDR_W'(INST_BYTES);

    // The counter only runs in FETCH; a redirect or a capture restarts it, so
    // every fetch sees a fresh ROM_LATENCY+1 cycle window.
    fetch_wait_ctr u_wait_ctr (
        .clock   (clock),
        .reset   (reset),
        .i_clr   ((r_state != FETCH) || redirect_valid || w_wait_done),
        .i_en    (r_state == FETCH),
        .o_count (w_wait_cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    // A redirect wins over a capture on the same edge: the
                    // ROM word belongs to the abandoned PC and is dropped.
                    if (redirect_valid) begin
                        if (w_aligned) begin
                            r_pc <= redirect_target;
                        end else begin
                            r_fault <= 1'b1;
                            r_state <= HALT;
                        end
                    end else if (w_wait_done) begin
                        r_ir       <= rom_inst;
                        r_ir_pc    <= r_pc;
                        r_pc       <= w_pc_next;
                        r_ir_valid <= 1'b1;
                        r_state    <= VALID;
                    end
                end
                VALID: begin
                    // A redirect alongside ir_ready still retires the IR once;
                    // it is simply not re-offered.
                    if (redirect_valid) begin
                        r_ir_valid <= 1'b0;
                        if (w_aligned) begin
                            r_pc    <= redirect_target;
                            r_state <= FETCH;
                        end else begin
                            r_fault <= 1'b1;
                            r_state <= HALT;
                        end
                    end else if (ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= FETCH;
                    end
                end
                HALT: begin
                    // Frozen until reset.
                end
                default: begin
                    r_ir_valid <= 1'b0;
                    r_state    <= FETCH;
                end
            endcase
        end
    end

    assign rom_addr       = r_pc;
    assign ir_out         = r_ir;
    assign ir_pc          = r_ir_pc;
    assign ir_valid       = r_ir_valid;
    assign misalign_fault = r_fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam int NWORDS = 1 << 15;
    localparam int LAT0   = 0;
    localparam int LAT3   = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ir_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [16:0] redirect_target = '0;

    logic [31:0] rom_mem [NWORDS];

    logic [16:0] rom_addr0, ir_pc0, rom_addr3, ir_pc3;
    logic [31:0] rom_inst0, ir_out0, rom_inst3, ir_out3;
    logic        ir_valid0, fault0, ir_valid3, fault3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    inst_fetch_unit #(.ADDR_W(17), .DATA_W(32), .RESET_PC(17'h0), .ROM_LATENCY(LAT0)) u_dut0 (
        .clock(clock), .reset(reset), .rom_addr(rom_addr0), .rom_inst(rom_inst0),
        .ir_out(ir_out0), .ir_pc(ir_pc0), .ir_valid(ir_valid0), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .misalign_fault(fault0)
    );

    inst_fetch_unit #(.ADDR_W(17), .DATA_W(32), .RESET_PC(17'h0), .ROM_LATENCY(LAT3)) u_dut3 (
        .clock(clock), .reset(reset), .rom_addr(rom_addr3), .rom_inst(rom_inst3),
        .ir_out(ir_out3), .ir_pc(ir_pc3), .ir_valid(ir_valid3), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .misalign_fault(fault3)
    );

    // ROM models: latency 0 is an async read; latency 3 returns junk until the
    // address has been held for 3 edges, so an early capture is visible.
    assign rom_inst0 = rom_mem[rom_addr0[16:2]];

    logic [16:0] held_addr3;
    int          age3;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            held_addr3 <= '0;
            age3       <= 0;
        end else if (rom_addr3 == held_addr3) begin
            age3 <= (age3 < 8) ? age3 + 1 : age3;
        end else begin
            held_addr3 <= rom_addr3;
            age3       <= 1;
        end
    end
    assign rom_inst3 = (rom_addr3 == held_addr3 && age3 >= LAT3) ? rom_mem[rom_addr3[16:2]]
                                                                 : 32'hDEAD_BEEF;

    // Reference model: one entry per DUT (0: latency 0, 1: latency 3).
    int          m_lat   [2] = '{LAT0, LAT3};
    logic [16:0] m_pc    [2];
    logic [31:0] m_ir    [2];
    logic [16:0] m_irpc  [2];
    bit          m_valid [2];
    bit          m_fault [2];
    bit          m_halt  [2];
    int          m_left  [2];   // edges still needed before the IR is captured

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = 17'h0;
            m_ir[i]    = '0;
            m_irpc[i]  = '0;
            m_valid[i] = 1'b0;
            m_fault[i] = 1'b0;
            m_halt[i]  = 1'b0;
            m_left[i]  = m_lat[i] + 1;
        end
    endtask

    task automatic model_step(input int i, input bit rv, input logic [16:0] tgt, input bit rdy);
        if (m_halt[i]) return;
        if (rv) begin
            m_valid[i] = 1'b0;
            if (tgt[1:0] != 2'b00) begin
                m_fault[i] = 1'b1;
                m_halt[i]  = 1'b1;
            end else begin
                m_pc[i]   = tgt;
                m_left[i] = m_lat[i] + 1;
            end
        end else if (m_valid[i]) begin
            if (rdy) begin
                m_valid[i] = 1'b0;
                m_left[i]  = m_lat[i] + 1;
            end
        end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_ir[i]    = rom_mem[m_pc[i][16:2]];
                m_irpc[i]  = m_pc[i];
                m_pc[i]    = m_pc[i] + 17'd4;
                m_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic check_one(input string ph, input int i, input logic [16:0] addr,
                             input logic vld, input logic flt, input logic [31:0] ir,
                             input logic [16:0] irpc);
        check($sformatf("%s_u%0d_addr", ph, i), 32'(addr), 32'(m_pc[i]));
        check($sformatf("%s_u%0d_valid", ph, i), 32'(vld), 32'(m_valid[i]));
        check($sformatf("%s_u%0d_fault", ph, i), 32'(flt), 32'(m_fault[i]));
        check($sformatf("%s_u%0d_ir", ph, i), ir, m_ir[i]);
        check($sformatf("%s_u%0d_irpc", ph, i), 32'(irpc), 32'(m_irpc[i]));
    endtask

    task automatic check_all(input string ph);
        check_one(ph, 0, rom_addr0, ir_valid0, fault0, ir_out0, ir_pc0);
        check_one(ph, 1, rom_addr3, ir_valid3, fault3, ir_out3, ir_pc3);
    endtask

    // Called at a falling edge: applies inputs for the next rising edge,
    // advances the model, and checks outputs at the following falling edge.
    task automatic cycle(input bit rv, input logic [16:0] tgt, input bit rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        ir_ready        = rdy;
        for (int i = 0; i < 2; i++) model_step(i, rv, tgt, rdy);
        @(posedge clock);
        @(negedge clock);
        check_all("cyc");
    endtask

    // Short asynchronous pulse between edges; outputs must clear while it is high.
    task automatic do_reset();
        redirect_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_addr0", 32'(rom_addr0), 32'h0);
        check("rst_fault0", 32'(fault0), 32'h0);
        check("rst_valid0", 32'(ir_valid0), 32'h0);
        check("rst_fault3", 32'(fault3), 32'h0);
        check("rst_valid3", 32'(ir_valid3), 32'h0);
        check_all("rst");
        #1 reset = 1'b0;
    endtask

    task automatic random_run(input int n, input int misalign_odds);
        bit          rv;
        logic [16:0] tgt;
        for (int k = 0; k < n; k++) begin
            rv  = ($urandom_range(0, 7) == 0);
            tgt = 17'($urandom) & 17'h1FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 17'h1FFF0 + 17'(4 * $urandom_range(0, 3));
            if (misalign_odds > 0 && $urandom_range(0, misalign_odds - 1) == 0)
                tgt[1:0] = 2'($urandom_range(1, 3));
            cycle(rv, tgt, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) rom_mem[i] = $urandom;
        rom_mem[0]          = 32'h0020_0093;
        rom_mem[NWORDS - 1] = 32'h0000_0013;

        @(negedge clock);
        do_reset();

        // First fetch after reset lands one edge later.
        cycle(1'b0, '0, 1'b1);
        check("t1_valid", 32'(ir_valid0), 32'h1);
        check("t1_ir", ir_out0, 32'h0020_0093);
        check("t1_irpc", 32'(ir_pc0), 32'h0);
        check("t1_addr", 32'(rom_addr0), 32'h4);

        // Decode stalls: IR, its PC and the ROM address hold.
        repeat (5) cycle(1'b0, '0, 1'b0);
        check("t2_ir", ir_out0, 32'h0020_0093);
        check("t2_irpc", 32'(ir_pc0), 32'h0);
        check("t2_addr", 32'(rom_addr0), 32'h4);
        check("t2_valid", 32'(ir_valid0), 32'h1);
        cycle(1'b0, '0, 1'b1);
        check("t2_drop", 32'(ir_valid0), 32'h0);
        cycle(1'b0, '0, 1'b0);
        check("t2_ir1", ir_out0, rom_mem[1]);
        check("t2_irpc1", 32'(ir_pc0), 32'h4);

        // Redirect together with the handshake.
        cycle(1'b1, 17'h18, 1'b1);
        check("t3_drop", 32'(ir_valid0), 32'h0);
        check("t3_addr", 32'(rom_addr0), 32'h18);
        cycle(1'b0, '0, 1'b0);
        check("t3_ir", ir_out0, rom_mem[6]);
        check("t3_irpc", 32'(ir_pc0), 32'h18);

        // Top-of-memory wrap.
        cycle(1'b1, 17'h1FFFC, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("t6_ir", ir_out0, 32'h0000_0013);
        check("t6_irpc", 32'(ir_pc0), 32'h1FFFC);
        check("t6_addr", 32'(rom_addr0), 32'h0);

        random_run(600, 0);

        // Latency-3 fetch interrupted in its 2nd wait cycle.
        do_reset();
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 17'h40, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 1'b1);
            check("t5_wait", 32'(ir_valid3), 32'h0);
        end
        cycle(1'b0, '0, 1'b1);
        check("t5_valid", 32'(ir_valid3), 32'h1);
        check("t5_irpc", 32'(ir_pc3), 32'h40);
        check("t5_ir", ir_out3, rom_mem[16]);

        random_run(200, 0);

        // Misaligned redirect halts both units until reset.
        cycle(1'b1, 17'h1A, 1'($urandom_range(0, 1)));
        check("t4_fault0", 32'(fault0), 32'h1);
        check("t4_fault3", 32'(fault3), 32'h1);
        random_run(20, 0);
        check("t4_hold_valid0", 32'(ir_valid0), 32'h0);
        check("t4_hold_fault0", 32'(fault0), 32'h1);
        do_reset();
        random_run(150, 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
